// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the writeback stage
package wb_pkg;

  localparam int WB_REGI_CONT = 4;
  localparam int WB_DATA_SIZE = 8;

  typedef struct packed {
    logic [WB_REGI_CONT-1:0] wa;
    logic [WB_DATA_SIZE-1:0] wd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LQ   = 2'd2,
    SRC_LD   = 2'd3
  } wb_src_e;

  function automatic logic addr_hit(input logic [WB_REGI_CONT-1:0] a,
                                    input logic [WB_REGI_CONT-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - FIFO of pending load results with per-entry wa/valid view
module wb_load_queue
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter int  AW      = WB_REGI_CONT,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][AW-1:0]   ent_wa
);

  localparam int PW = $clog2(DEPTH);

  entry_t             mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        cnt;
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_nxt;

  // Payload storage needs no reset; valid_q alone says what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    valid_nxt = valid_q;
    if (pop)  valid_nxt[rd_ptr] = 1'b0;
    if (push) valid_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_wa[i] = mem[i].wa;
    end
  end

  assign head      = mem[rd_ptr];
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign ent_valid = valid_q;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback arbiter (ALU > queued load > cut-through load),
// registered register-file write port, bypass and load-hazard stall
module wb_stage
  import wb_pkg::*;
#(
  parameter int REGI_CONT = WB_REGI_CONT,
  parameter int DATA_SIZE = WB_DATA_SIZE,
  parameter int LQ_DEPTH  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        alu_valid_i,
  input  logic [REGI_CONT-1:0]        alu_wa_i,
  input  logic [DATA_SIZE-1:0]        alu_wd_i,
  input  logic                        ld_valid_i,
  output logic                        ld_ready_o,
  input  logic [REGI_CONT-1:0]        ld_wa_i,
  input  logic [DATA_SIZE-1:0]        ld_wd_i,
  output logic                        we3_o,
  output logic [REGI_CONT-1:0]        wa3_o,
  output logic [DATA_SIZE-1:0]        wd3_o,
  input  logic [REGI_CONT-1:0]        ra1_i,
  input  logic [REGI_CONT-1:0]        ra2_i,
  output logic                        fwd1_hit_o,
  output logic                        fwd2_hit_o,
  output logic [DATA_SIZE-1:0]        fwd1_data_o,
  output logic [DATA_SIZE-1:0]        fwd2_data_o,
  output logic                        stall_o,
  output logic [$clog2(LQ_DEPTH):0]   lq_count_o
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  typedef struct packed {
    logic [REGI_CONT-1:0] wa;
    logic [DATA_SIZE-1:0] wd;
  } ent_t;

  ent_t                             lq_head;
  ent_t                             ld_ent;
  ent_t                             win;
  logic [CW-1:0]                    lq_count;
  logic                             lq_empty;
  logic [LQ_DEPTH-1:0]              lq_valid;
  logic [LQ_DEPTH-1:0][REGI_CONT-1:0] lq_wa;
  logic                             ld_acc;
  logic                             lq_push;
  logic                             lq_pop;
  logic                             hazard;
  wb_src_e                          src;

  assign ld_ent = '{wa: ld_wa_i, wd: ld_wd_i};

  // Ready looks only at the current count: a same-cycle pop never opens a slot.
  assign ld_ready_o = (lq_count < CW'(LQ_DEPTH));
  assign ld_acc     = ld_valid_i && ld_ready_o;

  always_comb begin
    src = SRC_NONE;
    if (alu_valid_i)    src = SRC_ALU;
    else if (!lq_empty) src = SRC_LQ;
    else if (ld_acc)    src = SRC_LD;
  end

  always_comb begin
    win = '0;
    case (src)
      SRC_ALU: win = '{wa: alu_wa_i, wd: alu_wd_i};
      SRC_LQ:  win = lq_head;
      SRC_LD:  win = ld_ent;
      default: win = '0;
    endcase
  end

  assign lq_push = ld_acc && (src != SRC_LD);
  assign lq_pop  = (src == SRC_LQ);

  wb_load_queue #(
    .DEPTH   (LQ_DEPTH),
    .AW      (REGI_CONT),
    .entry_t (ent_t)
  ) u_lq (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .push      (lq_push),
    .push_data (ld_ent),
    .pop       (lq_pop),
    .head      (lq_head),
    .count     (lq_count),
    .empty     (lq_empty),
    .ent_valid (lq_valid),
    .ent_wa    (lq_wa)
  );

  // Address/data hold their last value on idle cycles; only we3 drops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we3_o <= 1'b0;
      wa3_o <= '0;
      wd3_o <= '0;
    end else begin
      we3_o <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        wa3_o <= win.wa;
        wd3_o <= win.wd;
      end
    end
  end

  // A load pushed this cycle is already pending from decode's point of view.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_valid[i] && ((lq_wa[i] == ra1_i) || (lq_wa[i] == ra2_i))) hazard = 1'b1;
    end
    if (lq_push && ((ld_wa_i == ra1_i) || (ld_wa_i == ra2_i))) hazard = 1'b1;
  end

  assign stall_o     = hazard;
  assign fwd1_hit_o  = we3_o && (wa3_o == ra1_i);
  assign fwd2_hit_o  = we3_o && (wa3_o == ra2_i);
  assign fwd1_data_o = wd3_o;
  assign fwd2_data_o = wd3_o;
  assign lq_count_o  = lq_count;

endmodule
